// File: rtl/dvi_fb_arbiter_pkg.sv
// dvi_fb_arbiter_pkg: pixel type, screen geometry and framebuffer sizing helpers
// No ports; functions take the scale shift S and return framebuffer width/height/field widths.
package dvi_fb_arbiter_pkg;
    typedef logic [23:0] rgb_t;
    typedef enum logic [1:0] {PORT_IDLE, PORT_READ, PORT_WRITE} port_t;
    localparam int SCREEN_H_RES = 640;
    localparam int SCREEN_V_RES = 480;
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;
    localparam int FB_SCALE_SHIFT = 0;
    function automatic int fb_w(input int s);
        return SCREEN_H_RES >> s;
    endfunction
    function automatic int fb_h(input int s);
        return SCREEN_V_RES >> s;
    endfunction
    // +1 keeps the first out-of-range coordinate representable even for power-of-two sizes
    function automatic int fb_x_w(input int s);
        return $clog2(fb_w(s) + 1);
    endfunction
    function automatic int fb_y_w(input int s);
        return $clog2(fb_h(s) + 1);
    endfunction
    function automatic int fb_addr_w(input int s);
        return $clog2(fb_w(s) * fb_h(s));
    endfunction
endpackage

// File: rtl/dvi_fb_arbiter_pipe.sv
// dvi_pipe: synchronous-reset shift register, DEPTH stages of WIDTH bits
// Ports: clk_i clock, rst_i sync reset (clears all stages), d_i input, q_o input delayed DEPTH cycles.
module dvi_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign q_o = stage[DEPTH-1];
endmodule

// File: rtl/dvi_fb_arbiter.sv
// dvi_fb_arbiter: shares the single-port framebuffer RAM between scan-out reads and one pixel writer
// Ports: clk_i/rst_i pixel clock and sync reset; hsync_i/vsync_i/pixel_x_i/pixel_y_i/visible_range_i
// from dvi_sync; wr_valid_i/wr_ready_o/wr_x_i/wr_y_i/wr_data_i writer handshake; mem_addr_o/mem_we_o/
// mem_wdata_o registered RAM port, mem_rdata_i read data one cycle after the address;
// rgb_o/hsync_o/vsync_o/de_o video out, all three cycles behind the inputs.
module dvi_fb_arbiter
    import dvi_fb_arbiter_pkg::*;
#(
    parameter int SCALE_SHIFT = FB_SCALE_SHIFT,
    parameter int RAM_LAT = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              hsync_i,
    input  logic                              vsync_i,
    input  logic [X_POS_W-1:0]                pixel_x_i,
    input  logic [Y_POS_W-1:0]                pixel_y_i,
    input  logic                              visible_range_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [fb_x_w(SCALE_SHIFT)-1:0]    wr_x_i,
    input  logic [fb_y_w(SCALE_SHIFT)-1:0]    wr_y_i,
    input  rgb_t                              wr_data_i,
    output logic [fb_addr_w(SCALE_SHIFT)-1:0] mem_addr_o,
    output logic                              mem_we_o,
    output rgb_t                              mem_wdata_o,
    input  rgb_t                              mem_rdata_i,
    output rgb_t                              rgb_o,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              de_o
);
    localparam int FB_W = fb_w(SCALE_SHIFT);
    localparam int FB_H = fb_h(SCALE_SHIFT);
    localparam int FB_X_W = fb_x_w(SCALE_SHIFT);
    localparam int FB_Y_W = fb_y_w(SCALE_SHIFT);
    localparam int FB_ADDR_W = fb_addr_w(SCALE_SHIFT);
    localparam logic [X_POS_W-1:0] X_MASK = X_POS_W'((1 << SCALE_SHIFT) - 1);

    port_t port_q, port_d;
    logic need, wr_ok, wr_take, rd_done;
    logic [FB_ADDR_W-1:0] rd_addr, wr_addr;
    rgb_t hold;

    // Only the first column of each scaled pixel fetches; the mask is empty when SCALE_SHIFT is 0.
    always_comb begin
        need = visible_range_i && (pixel_x_i & X_MASK) == '0;
        wr_ready_o = !rst_i && !need;
        port_d = need ? PORT_READ : (wr_valid_i && wr_ready_o) ? PORT_WRITE : PORT_IDLE;
        wr_ok = wr_x_i < FB_X_W'(FB_W) && wr_y_i < FB_Y_W'(FB_H);
        wr_take = port_d == PORT_WRITE && wr_ok;
        rd_addr = FB_ADDR_W'(pixel_y_i >> SCALE_SHIFT) * FB_ADDR_W'(FB_W)
                + FB_ADDR_W'(pixel_x_i >> SCALE_SHIFT);
        wr_addr = FB_ADDR_W'(wr_y_i) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(wr_x_i);
    end

    // Out-of-range writes complete the handshake but leave the port idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            port_q <= PORT_IDLE;
            mem_we_o <= 1'b0;
            mem_addr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            port_q <= port_d;
            mem_we_o <= wr_take;
            mem_addr_o <= port_d == PORT_READ ? rd_addr : wr_take ? wr_addr : mem_addr_o;
            mem_wdata_o <= wr_take ? wr_data_i : mem_wdata_o;
        end
    end

    dvi_pipe #(.WIDTH(1), .DEPTH(RAM_LAT)) u_rd_pipe (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i(port_q == PORT_READ),
        .q_o(rd_done)
    );

    dvi_pipe #(.WIDTH(3), .DEPTH(3)) u_sync_pipe (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i({hsync_i, vsync_i, visible_range_i}),
        .q_o({hsync_o, vsync_o, de_o})
    );

    // Holding the last fetched pixel between reads produces the horizontal doubling.
    always_ff @(posedge clk_i) begin
        if (rst_i) hold <= '0;
        else if (rd_done) hold <= mem_rdata_i;
    end

    assign rgb_o = de_o ? hold : '0;
endmodule

// File: tb/tb_dvi_fb_arbiter.sv
// tb_dvi_fb_arbiter: scoreboard bench driving a 1:1 and a 2x2-scaled arbiter from shared sync inputs
module tb_dvi_fb_arbiter;
    import dvi_fb_arbiter_pkg::*;

    typedef struct {int due; logic h; logic v; logic de; rgb_t rgb;} vid_t;
    typedef struct {int due; int addr; rgb_t data;} wr_t;

    logic clk = 0, rst = 1, hsync = 0, vsync = 0, vis = 0;
    logic [9:0] px = 0, py = 0;
    logic wv0 = 0, wv1 = 0;
    logic [9:0] wx0 = 0, sx0 = 0;
    logic [8:0] wy0 = 0, sy0 = 0;
    logic [8:0] wx1 = 0, sx1 = 0;
    logic [7:0] wy1 = 0, sy1 = 0;
    rgb_t wd0 = 0, wd1 = 0, sd0 = 0, sd1 = 0;
    logic rdy0, rdy1, we0, we1, hs0, hs1, vs0, vs1, de0, de1;
    logic [18:0] ma0;
    logic [16:0] ma1;
    rgb_t mwd0, mwd1, rgb0, rgb1;
    rgb_t rd0 = 0, rd1 = 0;
    int cnt = 0, checks = 0, errors = 0;
    bit mon_on = 0;
    bit acc[2];
    bit pend[2];
    rgb_t last[2];
    vid_t vq[2][$];
    wr_t wq[2][$];
    rgb_t mdl[2][int];
    rgb_t ram[2][int];

    dvi_fb_arbiter #(.SCALE_SHIFT(0), .RAM_LAT(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync),
        .pixel_x_i(px), .pixel_y_i(py), .visible_range_i(vis),
        .wr_valid_i(wv0), .wr_ready_o(rdy0), .wr_x_i(wx0), .wr_y_i(wy0), .wr_data_i(wd0),
        .mem_addr_o(ma0), .mem_we_o(we0), .mem_wdata_o(mwd0), .mem_rdata_i(rd0),
        .rgb_o(rgb0), .hsync_o(hs0), .vsync_o(vs0), .de_o(de0)
    );

    dvi_fb_arbiter #(.SCALE_SHIFT(1), .RAM_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync),
        .pixel_x_i(px), .pixel_y_i(py), .visible_range_i(vis),
        .wr_valid_i(wv1), .wr_ready_o(rdy1), .wr_x_i(wx1), .wr_y_i(wy1), .wr_data_i(wd1),
        .mem_addr_o(ma1), .mem_we_o(we1), .mem_wdata_o(mwd1), .mem_rdata_i(rd1),
        .rgb_o(rgb1), .hsync_o(hs1), .vsync_o(vs1), .de_o(de1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    function automatic rgb_t pat(input int a);
        return 24'((a * 40503) ^ (a >> 3) ^ 24'hA5C3E1);
    endfunction
    function automatic rgb_t ram_rd(input int k, input int a);
        return ram[k].exists(a) ? ram[k][a] : pat(a);
    endfunction
    function automatic rgb_t mdl_rd(input int k, input int a);
        return mdl[k].exists(a) ? mdl[k][a] : pat(a);
    endfunction

    // Behavioural single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (we0) ram[0][int'(ma0)] = mwd0;
        if (we1) ram[1][int'(ma1)] = mwd1;
        rd0 <= ram_rd(0, int'(ma0));
        rd1 <= ram_rd(1, int'(ma1));
    end

    task automatic chk_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, required %0d", name, cnt, got, exp);
        end
    endtask

    task automatic chk_rdy(input int k, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ready%0d cycle %0d: wr_ready_o=%b, required %b", k, cnt, got, exp);
        end
    endtask

    task automatic chk_wr(input int k, input logic we, input int a, input rgb_t d);
        wr_t e;
        bit exp;
        exp = wq[k].size() != 0 && wq[k][0].due == cnt;
        checks++;
        if (we !== exp) begin
            errors++;
            $display("FAIL we%0d cycle %0d: mem_we_o=%b, required %b", k, cnt, we, exp);
        end
        if (exp) begin
            e = wq[k].pop_front();
            checks++;
            if (a != e.addr || d !== e.data) begin
                errors++;
                $display("FAIL wr%0d cycle %0d: addr %0d data %h, required addr %0d data %h",
                         k, cnt, a, d, e.addr, e.data);
            end
        end
    endtask

    task automatic chk_vid(input int k, input logic h, input logic v, input logic de, input rgb_t rgb);
        vid_t e;
        if (vq[k].size() != 0 && vq[k][0].due == cnt) begin
            e = vq[k].pop_front();
            checks++;
            if ({h, v, de, rgb} !== {e.h, e.v, e.de, e.rgb}) begin
                errors++;
                $display("FAIL vid%0d cycle %0d: h%b v%b de%b rgb %h, required h%b v%b de%b rgb %h",
                         k, cnt, h, v, de, rgb, e.h, e.v, e.de, e.rgb);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk_wr(0, we0, int'(ma0), mwd0);
            chk_wr(1, we1, int'(ma1), mwd1);
            chk_vid(0, hs0, vs0, de0, rgb0);
            chk_vid(1, hs1, vs1, de1, rgb1);
        end
    end

    task automatic post0(input int x, input int y, input rgb_t d);
        pend[0] = 1; sx0 = 10'(x); sy0 = 9'(y); sd0 = d;
    endtask
    task automatic post1(input int x, input int y, input rgb_t d);
        pend[1] = 1; sx1 = 9'(x); sy1 = 8'(y); sd1 = d;
    endtask

    task automatic push_wr(input int k, input int a, input rgb_t d);
        mdl[k][a] = d;
        wq[k].push_back('{cnt + 1, a, d});
    endtask

    // One input cycle: drive, check the grant, and push the expected write and video responses.
    task automatic cyc(input logic r, input logic h, input logic v, input logic s, input int x, input int y);
        bit nd0, nd1;
        @(posedge clk);
        #1;
        if (acc[0]) wv0 = 0;
        if (acc[1]) wv1 = 0;
        if (pend[0]) begin wv0 = 1; wx0 = sx0; wy0 = sy0; wd0 = sd0; pend[0] = 0; end
        if (pend[1]) begin wv1 = 1; wx1 = sx1; wy1 = sy1; wd1 = sd1; pend[1] = 0; end
        rst = r; hsync = h; vsync = v; vis = s; px = 10'(x); py = 10'(y);
        #1;
        nd0 = s;
        nd1 = s && x % 2 == 0;
        chk_rdy(0, rdy0, !r && !nd0);
        chk_rdy(1, rdy1, !r && !nd1);
        acc[0] = wv0 && !r && !nd0;
        acc[1] = wv1 && !r && !nd1;
        if (acc[0] && wx0 < 640 && wy0 < 480) push_wr(0, int'(wy0) * 640 + int'(wx0), wd0);
        if (acc[1] && wx1 < 320 && wy1 < 240) push_wr(1, int'(wy1) * 320 + int'(wx1), wd1);
        if (nd0) last[0] = mdl_rd(0, y * 640 + x);
        if (nd1) last[1] = mdl_rd(1, (y / 2) * 320 + x / 2);
        if (r) begin last[0] = 0; last[1] = 0; end
        for (int k = 0; k < 2; k++)
            vq[k].push_back('{cnt + 3, h && !r, v && !r, s && !r, (s && !r) ? last[k] : 24'h0});
    endtask

    initial begin
        last[0] = 0;
        last[1] = 0;
        post0(1, 1, 24'h111111);
        post1(2, 1, 24'h222222);
        cyc(1, 0, 0, 0, 0, 0);
        mon_on = 1;
        repeat (4) cyc(1, 1, 1, 1, 0, 0);
        chk_eq("rst_addr0", int'(ma0), 0);
        chk_eq("rst_wdata0", int'(mwd0), 0);
        chk_eq("rst_addr1", int'(ma1), 0);
        chk_eq("rst_wdata1", int'(mwd1), 0);
        cyc(0, 0, 0, 0, 700, 490);
        post0(3, 2, 24'hABCDEF);
        post1(3, 2, 24'h13579B);
        cyc(0, 1, 0, 0, 701, 490);
        cyc(0, 0, 1, 0, 702, 490);
        post0(640, 0, 24'hDEAD00);
        post1(0, 240, 24'hBEEF00);
        cyc(0, 0, 0, 0, 703, 490);
        post0(7, 0, 24'h00FF00);
        post1(319, 239, 24'h0F0F0F);
        cyc(0, 0, 0, 0, 704, 490);
        cyc(0, 0, 0, 0, 705, 490);
        post0(5, 1, 24'h123456);
        for (int x = 0; x < 640; x++) cyc(0, 0, 0, 1, x, 10);
        for (int x = 640; x < 660; x++) cyc(0, x >= 656, 0, 0, x, 10);
        for (int x = 0; x < 640; x++) begin
            if (!wv1 || acc[1]) post1((x / 2) % 320, 100, 24'(x * 3 + 1));
            cyc(0, 0, 0, 1, x, 5);
        end
        for (int x = 640; x < 650; x++) cyc(0, 0, 0, 0, x, 5);
        for (int i = 0; i < 400; i++) begin
            if ((!wv0 || acc[0]) && $urandom_range(0, 1) == 1)
                post0($urandom_range(0, 660), $urandom_range(0, 479), 24'($urandom));
            if ((!wv1 || acc[1]) && $urandom_range(0, 1) == 1)
                post1($urandom_range(0, 330), $urandom_range(0, 239), 24'($urandom));
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 639), $urandom_range(0, 479));
        end
        @(posedge clk);
        #1;
        wv0 = 0;
        wv1 = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_eq("vid_left", vq[k].size(), 0);
            chk_eq("wr_left", wq[k].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
